// File: rtl/fmap_replay_buffer_pkg.sv
// fmap_replay_buffer_pkg: shared VGG feature-map widths, frame sides and replay FSM states
package fmap_replay_buffer_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int CH_DEF = 8;
  localparam int WIDTH_DEF = 56;
  typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} state_e;
endpackage

// File: rtl/fmap_ram.sv
// fmap_ram: simple dual-port synchronous RAM, registered read data, unreset contents
module fmap_ram #(
  parameter int W = 256,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q, rdata_d;
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  // only the output register is reset so replay data reads as zero under reset
  always_comb rdata_d = re ? mem[raddr] : rdata_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata_q <= '0;
    else rdata_q <= rdata_d;
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/fmap_replay_buffer.sv
// fmap_replay_buffer: captures one feature-map frame from a valid-only stream,
// then replays it in raster order with a pause-able, valid-qualified output.
module fmap_replay_buffer
  import fmap_replay_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CH = CH_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH*CH-1:0] i_data,
  input  logic                     valid_in,
  input  logic                     pause,
  output logic [DATA_WIDTH*CH-1:0] o_data,
  output logic                     valid_out,
  output logic                     frame_done,
  output logic                     busy,
  output logic                     overflow
);
  localparam int DEPTH = WIDTH * WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  state_e state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic valid_q, valid_d, done_q, done_d, over_q, over_d;
  logic wr_en, rd_en;
  always_comb begin
    wr_en = state_q == FILL && valid_in;
    rd_en = state_q == DRAIN && !pause;
    wr_addr_d = wr_en ? (wr_addr_q == LAST ? '0 : wr_addr_q + AW'(1)) : wr_addr_q;
    rd_addr_d = rd_en ? (rd_addr_q == LAST ? '0 : rd_addr_q + AW'(1)) : rd_addr_q;
    state_d = (wr_en && wr_addr_q == LAST) ? DRAIN : (rd_en && rd_addr_q == LAST) ? FILL : state_q;
    valid_d = rd_en;
    done_d = rd_en && rd_addr_q == LAST;
    over_d = over_q || (state_q == DRAIN && valid_in);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      valid_q <= 1'b0;
      done_q <= 1'b0;
      over_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      valid_q <= valid_d;
      done_q <= done_d;
      over_q <= over_d;
    end
  end
  fmap_ram #(.W(DATA_WIDTH * CH), .DEPTH(DEPTH)) u_ram (
    .clk(clk), .rst(rst),
    .we(wr_en), .waddr(wr_addr_q), .wdata(i_data),
    .re(rd_en), .raddr(rd_addr_q), .rdata(o_data)
  );
  assign valid_out = valid_q;
  assign frame_done = done_q;
  assign busy = state_q == DRAIN;
  assign overflow = over_q;
endmodule

// File: tb/tb_fmap_replay_buffer.sv
// tb_fmap_replay_buffer: randomized frames against a frame-level reference model (4x4),
// plus one full 56x56 capture/replay on a second instance.
module tb_fmap_replay_buffer;
  localparam int DW = 32, CH = 8, W = DW * CH, D = 16, D56 = 56 * 56;
  typedef logic [W-1:0] word_t;
  logic clk = 0, rst = 0;
  word_t i_data = '0, o_data;
  logic valid_in = 0, pause = 0, valid_out, frame_done, busy, overflow;
  word_t i_data_b = '0, o_data_b;
  logic valid_in_b = 0, valid_out_b, frame_done_b, busy_b, overflow_b;
  int n_cmp = 0, n_err = 0;
  word_t frame [D];
  bit m_drain = 0, e_valid = 0, e_done = 0, e_over = 0;
  int m_idx = 0;
  word_t e_data = '0;
  fmap_replay_buffer #(.DATA_WIDTH(DW), .CH(CH), .WIDTH(4)) dut (
    .clk(clk), .rst(rst), .i_data(i_data), .valid_in(valid_in), .pause(pause),
    .o_data(o_data), .valid_out(valid_out), .frame_done(frame_done), .busy(busy), .overflow(overflow)
  );
  fmap_replay_buffer #(.DATA_WIDTH(DW), .CH(CH), .WIDTH(56)) dut_b (
    .clk(clk), .rst(rst), .i_data(i_data_b), .valid_in(valid_in_b), .pause(1'b0),
    .o_data(o_data_b), .valid_out(valid_out_b), .frame_done(frame_done_b), .busy(busy_b), .overflow(overflow_b)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input word_t got, input word_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic word_t rnd();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic check_outputs();
    check("valid_out", W'(valid_out), W'(e_valid));
    check("frame_done", W'(frame_done), W'(e_done));
    check("busy", W'(busy), W'(m_drain));
    check("overflow", W'(overflow), W'(e_over));
    check("o_data", o_data, e_data);
  endtask
  // model: a frame is an array of accepted words, replayed in order one word per unpaused cycle
  task automatic step(input bit vin, input word_t d, input bit p);
    valid_in = vin;
    i_data = d;
    pause = p;
    e_valid = 0;
    e_done = 0;
    if (m_drain) begin
      if (vin) e_over = 1;
      if (!p) begin
        e_valid = 1;
        e_data = frame[m_idx];
        e_done = m_idx == D - 1;
        m_idx++;
        if (m_idx == D) begin m_drain = 0; m_idx = 0; end
      end
    end else if (vin) begin
      frame[m_idx] = d;
      m_idx++;
      if (m_idx == D) begin m_drain = 1; m_idx = 0; end
    end
    @(negedge clk);
    check_outputs();
  endtask
  task automatic fill(input int mode, input int base);
    int k, t;
    bit v;
    k = 0;
    t = 0;
    while (!m_drain) begin
      v = mode == 0 ? 1'b1 : mode == 1 ? (t % 2 == 0) : 1'($urandom_range(0, 1));
      step(v, mode == 2 ? rnd() : W'(base + k), 1'($urandom_range(0, 1)));
      if (v) k++;
      t++;
    end
  endtask
  task automatic drain(input int mode);
    int hold, burst;
    bit p, v;
    hold = 0;
    burst = 0;
    while (m_drain) begin
      p = mode == 1 ? (m_idx == 6 && hold < 3) : mode == 3 ? ($urandom_range(0, 3) == 0) : 1'b0;
      v = mode == 2 && (m_idx == 8 || m_idx == 9) && burst < 2;
      if (p) hold++;
      if (v) burst++;
      step(v, rnd(), p);
    end
  endtask
  task automatic do_reset();
    #3 rst = 0;
    valid_in = 0;
    pause = 0;
    m_drain = 0; m_idx = 0; e_valid = 0; e_done = 0; e_over = 0; e_data = '0;
    #1 check_outputs();
    @(negedge clk);
    check_outputs();
    rst = 1;
  endtask
  initial begin
    int got, dones;
    @(negedge clk);
    check_outputs();
    rst = 1;
    step(0, '0, 0);
    fill(0, 0); drain(0);
    fill(1, 0); drain(1);
    fill(2, 0); drain(2);
    fill(2, 0); drain(0);
    for (int i = 0; i < 7; i++) step(1, rnd(), 0);
    do_reset();
    fill(0, 100); drain(0);
    fill(0, 200); drain(0);
    fill(2, 0); drain(3);
    repeat (3) begin fill(2, 0); drain(3); end
    repeat (3) step(0, rnd(), 0);
    for (int i = 0; i < D56; i++) begin
      valid_in_b = 1;
      i_data_b = W'(i);
      @(negedge clk);
    end
    valid_in_b = 0;
    check("b_busy", W'(busy_b), W'(1));
    got = 0;
    dones = 0;
    for (int c = 0; c < D56 + 8; c++) begin
      @(negedge clk);
      if (valid_out_b) begin
        check("b_data", o_data_b, W'(got));
        if (frame_done_b) check("b_done_pos", W'(got), W'(D56 - 1));
        got++;
      end
      if (frame_done_b) dones++;
    end
    check("b_count", W'(got), W'(D56));
    check("b_dones", W'(dones), W'(1));
    check("b_overflow", W'(overflow_b), W'(0));
    check("b_busy_end", W'(busy_b), W'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
